eth_crc32: RTL and testbench



---
 rtl/eth_crc32_if.sv | 22 ++
 rtl/eth_crc32.sv | 57 +++++
 tb/tb_eth_crc32.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/eth_crc32_if.sv
// Byte stream and FCS result bundle for eth_crc32.
//   vld  : data qualifier, byte is folded into the CRC on the edge where it is high
//   data : message byte, bit 0 is the first bit on the wire
//   crc  : finished FCS in wire byte order (crc[31:24] transmitted first)
// master drives the byte stream and reads the FCS; slave is the CRC engine.
interface eth_crc32_if;
  logic        vld;
  logic [7:0]  data;
  logic [31:0] crc;

  modport master (
    output vld,
    output data,
    input  crc
  );

  modport slave (
    input  vld,
    input  data,
    output crc
  );
endinterface

// File: rtl/eth_crc32.sv
// Byte-serial IEEE 802.3 CRC-32 (FCS) generator/checker.
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   rst    : synchronous active-high reset; also restarts the CRC per frame
//   crc_if : slave side of eth_crc32_if (vld, data in; crc out)
// One byte is folded in per qualified clock with no pipeline delay, so crc
// reflects a byte one clock after it was sampled. crc holds while vld is low.
module eth_crc32 (
  input  logic        clk,
  input  logic        rst,
  eth_crc32_if.slave  crc_if
);

  localparam logic [31:0] Poly = 32'hEDB88320;
  localparam logic [31:0] Init = 32'hFFFFFFFF;

  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_inv;

  // Reflected LFSR, eight bit steps unrolled into one combinational update.
  function automatic logic [31:0] crc_byte(input logic [31:0] r_in, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = r_in;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) begin
        r = r ^ Poly;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= Init;
    end else begin
      crc_q <= crc_d;
    end
  end

  // data is only looked at when vld is high, so an undriven bus cannot leak in.
  always_comb begin
    crc_d = crc_q;
    if (crc_if.vld) begin
      crc_d = crc_byte(crc_q, crc_if.data);
    end
  end

  // Complement, then byte-swap so the first FCS byte on the wire is in [31:24].
  always_comb begin
    crc_inv    = ~crc_q;
    crc_if.crc = {crc_inv[7:0], crc_inv[15:8], crc_inv[23:16], crc_inv[31:24]};
  end

endmodule

// File: tb/tb_eth_crc32.sv
// Self-checking bench for eth_crc32: directed vectors with known FCS values,
// residue checks, reset priority, sparse vld, and random frames against a
// bitwise reference model.
module tb_eth_crc32;

  logic clk;
  logic rst;
  eth_crc32_if bus ();

  eth_crc32 dut (
    .clk    (clk),
    .rst    (rst),
    .crc_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total;
  int unsigned n_bad;
  logic [31:0] mdl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: the plain bit-at-a-time reflected CRC.
  function automatic logic [31:0] ref_next(input logic [31:0] r_in, input logic [7:0] d);
    logic [31:0] r;
    r = r_in;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ d[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_out(input logic [31:0] r);
    logic [31:0] c;
    c = ~r;
    return {c[7:0], c[15:8], c[23:16], c[31:24]};
  endfunction

  // All input changes happen 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl = 32'hFFFFFFFF;
  endtask

  task automatic feed(input logic [7:0] b);
    bus.vld  = 1'b1;
    bus.data = b;
    tick();
    bus.vld  = 1'b0;
    bus.data = 8'hxx;
    mdl = ref_next(mdl, b);
  endtask

  task automatic feed_check_seq();
    for (int i = 0; i < 9; i++) feed(8'h31 + 8'(i));
  endtask

  logic [31:0] fcs;
  int unsigned len;

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst      = 1'b1;
    bus.vld  = 1'b0;
    bus.data = 8'h00;
    mdl      = 32'hFFFFFFFF;
    tick();

    // Reset only, held while idle.
    do_reset();
    chk("reset", bus.crc, 32'h00000000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset_hold", bus.crc, 32'h00000000);
    end

    // Standard check value, back-to-back.
    do_reset();
    feed_check_seq();
    chk("check_b2b", bus.crc, 32'h2639F4CB);

    // Same string, one pulse per 4 clocks; crc must hold between pulses.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      feed(8'h31 + 8'(i));
      for (int g = 0; g < 3; g++) begin
        chk("sparse_hold", bus.crc, ref_out(mdl));
        tick();
      end
    end
    chk("check_sparse", bus.crc, 32'h2639F4CB);

    // Single-byte vectors.
    do_reset();
    feed(8'h00);
    chk("byte_00", bus.crc, 32'h8DEF02D2);
    do_reset();
    feed(8'h61);
    chk("byte_61", bus.crc, 32'h43BEB7E8);

    // Residue after check string plus its FCS.
    do_reset();
    feed_check_seq();
    feed(8'h26);
    feed(8'h39);
    feed(8'hF4);
    feed(8'hCB);
    chk("residue_check", bus.crc, 32'h1CDF4421);

    // Residue on a 60-byte zero-padded frame.
    do_reset();
    for (int i = 0; i < 60; i++) feed(8'h00);
    fcs = ref_out(mdl);
    chk("pad60_fcs", bus.crc, fcs);
    feed(fcs[31:24]);
    feed(fcs[23:16]);
    feed(fcs[15:8]);
    feed(fcs[7:0]);
    chk("pad60_residue", bus.crc, 32'h1CDF4421);

    // Reset beats vld mid-frame; the byte on that edge is dropped.
    do_reset();
    for (int i = 0; i < 4; i++) feed(8'h31 + 8'(i));
    rst      = 1'b1;
    bus.vld  = 1'b1;
    bus.data = 8'h35;
    tick();
    rst      = 1'b0;
    bus.vld  = 1'b0;
    mdl      = 32'hFFFFFFFF;
    chk("rst_priority", bus.crc, 32'h00000000);
    feed_check_seq();
    chk("after_rst_check", bus.crc, 32'h2639F4CB);

    // Random frames with random idle gaps.
    for (int f = 0; f < 40; f++) begin
      do_reset();
      len = $urandom_range(1, 200);
      for (int i = 0; i < int'(len); i++) begin
        feed(8'($urandom));
        repeat ($urandom_range(0, 3)) tick();
      end
      chk("rand_frame", bus.crc, ref_out(mdl));
      fcs = ref_out(mdl);
      feed(fcs[31:24]);
      feed(fcs[23:16]);
      feed(fcs[15:8]);
      feed(fcs[7:0]);
      chk("rand_residue", bus.crc, 32'h1CDF4421);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
